// File: rtl/alu_pkg.sv
// Shared encodings for the accumulator-ALU scheduler: op codes and FSM state values.
package alu_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

endpackage

// File: rtl/alu_rr_sched_if.sv
// Bundle of the two request channels, the datapath issue/done pair and the response channel.
// The slave side is the scheduler; the master side is its surroundings.
interface alu_rr_sched_if #(
  parameter int DW = 8
);

  logic          req0_valid;
  logic          req0_ready;
  logic [1:0]    req0_op;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [1:0]    req1_op;
  logic [DW-1:0] req1_data;

  logic          alu_start;
  logic [1:0]    alu_op;
  logic [DW-1:0] alu_operand;
  logic          alu_done;
  logic [DW-1:0] alu_result;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport slave (
    input  req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
    input  alu_done, alu_result, rsp_ready,
    output req0_ready, req1_ready, alu_start, alu_op, alu_operand,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
    output alu_done, alu_result, rsp_ready,
    input  req0_ready, req1_ready, alu_start, alu_op, alu_operand,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational: a lone requester wins,
// a tie goes to the port that did not win last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    if (valid == 2'b11) begin
      gnt_id = ~last;
    end else if (valid[1]) begin
      gnt_id = 1'b1;
    end
    grant = 2'b00;
    if (|valid) begin
      grant = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one accumulator datapath between two requesters; one op in flight, accept to rsp_valid >= 3 cycles.
// Requests are held off until the previous response handshakes; ena=0 freezes everything.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  alu_rr_sched_if.slave bus,
  output logic         busy,
  output logic [7:0]   op_count
);

  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic          last_grant;
  logic [1:0]    grant;
  logic          gnt_id;
  logic          timeout;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    op_q;
  logic [DW-1:0] operand_q;
  logic          id_q;
  logic [DW-1:0] rsp_data_q;
  logic          rsp_err_q;

  rr_arb2 u_arb (
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .last   (last_grant),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign timeout         = (wait_cnt == WAIT_LAST);
  assign bus.alu_op      = op_q;
  assign bus.alu_operand = operand_q;
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|grant) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.alu_done || timeout) state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are gated by rst so nothing handshakes while reset is held.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.alu_start  = 1'b0;
    bus.rsp_valid  = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        bus.req0_ready = ena && !rst && grant[0];
        bus.req1_ready = ena && !rst && grant[1];
      end
      S_ISSUE: bus.alu_start = ena && !rst;
      S_RESP:  bus.rsp_valid = !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      operand_q  <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wait_cnt   <= '0;
      op_count   <= 8'd0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (|grant) begin
            op_q       <= gnt_id ? bus.req1_op : bus.req0_op;
            operand_q  <= gnt_id ? bus.req1_data : bus.req0_data;
            id_q       <= gnt_id;
            last_grant <= gnt_id;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (bus.alu_done) begin
            rsp_data_q <= bus.alu_result;
            rsp_err_q  <= 1'b0;
          end else if (timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            op_count <= op_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed stimulus with a scoreboard: expected issues/responses are queued at stimulus time
// and popped by an independent datapath model and response monitor.
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       busy;
  logic [7:0] op_count;

  alu_rr_sched_if #(.DW(DW)) bus ();

  alu_rr_sched #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] op; logic [7:0] data; } req_t;
  typedef struct { logic [1:0] op; logic [7:0] operand; int dly; bit nodone; logic [7:0] res; } iss_t;
  typedef struct packed { logic id; logic [7:0] data; logic err; } rsp_t;

  req_t q0[$];
  req_t q1[$];
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, n_start = 0, wait_cyc = 0, n_rsp = 0;
  bit   hs0 = 1'b0, hs1 = 1'b0;
  iss_t dp_it;
  bit   dp_pend = 1'b0;
  int   dp_cnt = 0;
  logic [7:0] dp_res = 8'h00;
  rsp_t mon_e;
  int   lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit p, input logic [1:0] op, input logic [7:0] d,
                       input int dly, input bit nd, input logic [7:0] res);
    req_t r;
    iss_t it;
    rsp_t e;
    r.op = op;
    r.data = d;
    if (p) q1.push_back(r); else q0.push_back(r);
    it.op = op; it.operand = d; it.dly = dly; it.nodone = nd; it.res = res;
    iss_q.push_back(it);
    e.id = p; e.data = nd ? 8'h00 : res; e.err = nd;
    rsp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || iss_q.size() != 0 || rsp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_rsp_valid(input string name, output int latency);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.rsp_valid && n < 100);
    chk({name, "_rsp_seen"}, 32'(bus.rsp_valid), 32'd1);
    latency = cyc - acc_cyc;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.alu_start && n < 100);
    chk({name, "_start_seen"}, 32'(bus.alu_start), 32'd1);
  endtask

  task automatic chk_idle_zero(input string name);
    chk({name, "_busy"},      32'(busy),            32'd0);
    chk({name, "_rsp_valid"}, 32'(bus.rsp_valid),   32'd0);
    chk({name, "_rsp_id"},    32'(bus.rsp_id),      32'd0);
    chk({name, "_rsp_data"},  32'(bus.rsp_data),    32'd0);
    chk({name, "_rsp_err"},   32'(bus.rsp_err),     32'd0);
    chk({name, "_alu_start"}, 32'(bus.alu_start),   32'd0);
    chk({name, "_alu_op"},    32'(bus.alu_op),      32'd0);
    chk({name, "_alu_opnd"},  32'(bus.alu_operand), 32'd0);
    chk({name, "_op_count"},  32'(op_count),        32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (bus.alu_start) n_start++;
    if (busy && !bus.alu_start && !bus.rsp_valid) wait_cyc++;
    hs0 = bus.req0_valid && bus.req0_ready;
    hs1 = bus.req1_valid && bus.req1_ready;
    if (hs0 || hs1) acc_cyc = cyc;
  end

  // Requester drivers: present the head of each queue, pop after a handshake.
  initial begin
    bus.req0_valid = 1'b0; bus.req0_op = 2'd0; bus.req0_data = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_op = 2'd0; bus.req1_data = 8'h00;
    forever begin
      tick();
      if (hs0) begin void'(q0.pop_front()); hs0 = 1'b0; end
      if (hs1) begin void'(q1.pop_front()); hs1 = 1'b0; end
      bus.req0_valid = (q0.size() != 0);
      if (q0.size() != 0) begin bus.req0_op = q0[0].op; bus.req0_data = q0[0].data; end
      bus.req1_valid = (q1.size() != 0);
      if (q1.size() != 0) begin bus.req1_op = q1[0].op; bus.req1_data = q1[0].data; end
    end
  end

  // Datapath model: checks the issued op and answers after dly extra WAIT cycles.
  initial begin
    bus.alu_done = 1'b0;
    bus.alu_result = 8'h00;
    forever begin
      @(negedge clk);
      bus.alu_done = 1'b0;
      if (bus.alu_start) begin
        if (iss_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL alu_start_unexpected: got op=%0d operand=0x%0h, expected no issue", bus.alu_op, bus.alu_operand);
        end else begin
          dp_it = iss_q.pop_front();
          chk("alu_op", 32'(bus.alu_op), 32'(dp_it.op));
          chk("alu_operand", 32'(bus.alu_operand), 32'(dp_it.operand));
          dp_pend = !dp_it.nodone;
          dp_cnt = dp_it.dly;
          dp_res = dp_it.res;
        end
      end else if (dp_pend) begin
        if (dp_cnt == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_result = dp_res;
          dp_pend = 1'b0;
        end else begin
          dp_cnt--;
        end
      end
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (!rst && ena && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (rsp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d data=0x%0h err=%0d, expected no response", bus.rsp_id, bus.rsp_data, bus.rsp_err);
      end else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
        chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_idle_zero("reset");
    chk("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
    tick();
    rst = 1'b0;

    // Single ADD, done in the first WAIT cycle.
    n_start = 0;
    issue(1'b0, OP_ADD, 8'h05, 0, 1'b0, 8'h0D);
    wait_rsp_valid("t1", lat);
    chk("t1_latency", 32'(lat), 32'd3);
    drain("t1", 50);
    chk("t1_start_pulses", 32'(n_start), 32'd1);
    chk("t1_op_count", 32'(op_count), 32'd1);

    // Both requesters from reset: grants alternate starting with port 0.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 2'(i),     8'h10 + 8'(i), 0, 1'b0, 8'hA0 + 8'(i));
      issue(1'b1, 2'(3 - i), 8'h20 + 8'(i), 0, 1'b0, 8'hB0 + 8'(i));
    end
    drain("rr", 300);
    chk("rr_op_count", 32'(op_count), 32'd8);

    // No done: error response after exactly TIMEOUT WAIT cycles.
    wait_cyc = 0;
    issue(1'b1, OP_READ, 8'h00, 0, 1'b1, 8'h00);
    drain("to", 100);
    chk("to_wait_cycles", 32'(wait_cyc), 32'd16);

    // Done on the timeout cycle wins.
    wait_cyc = 0;
    issue(1'b0, OP_ADD, 8'h33, 15, 1'b0, 8'h77);
    drain("dt", 100);
    chk("dt_wait_cycles", 32'(wait_cyc), 32'd16);

    // Response backpressure.
    bus.rsp_ready = 1'b0;
    issue(1'b0, OP_LOAD, 8'h44, 0, 1'b0, 8'h55);
    wait_rsp_valid("bp", lat);
    tick();
    issue(1'b1, OP_ADD, 8'h66, 0, 1'b0, 8'h99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_rsp_data", 32'(bus.rsp_data), 32'h55);
      chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    tick();
    bus.rsp_ready = 1'b1;
    drain("bp", 100);

    // ena low for 3 cycles mid-WAIT, done afterwards.
    issue(1'b0, OP_SUB, 8'h21, 5, 1'b0, 8'h42);
    wait_start("en");
    tick();
    tick();
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("en_alu_start", 32'(bus.alu_start), 32'd0);
      chk("en_busy", 32'(busy), 32'd1);
      chk("en_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    ena = 1'b1;
    drain("en", 100);

    // ena low during a timing-out WAIT stretches it by exactly the frozen cycles.
    wait_cyc = 0;
    issue(1'b1, OP_LOAD, 8'h5A, 0, 1'b1, 8'h00);
    wait_start("enf");
    tick();
    tick();
    ena = 1'b0;
    repeat (3) tick();
    ena = 1'b1;
    drain("enf", 100);
    chk("enf_wait_cycles", 32'(wait_cyc), 32'd19);

    // Reset in WAIT; the later done pulse must be ignored and no response produced.
    issue(1'b0, OP_ADD, 8'hC3, 4, 1'b0, 8'hEE);
    void'(rsp_q.pop_back());
    wait_start("rs");
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_zero("rs");
    repeat (3) @(negedge clk);
    chk("rs_busy_later", 32'(busy), 32'd0);
    chk("rs_rsp_valid_later", 32'(bus.rsp_valid), 32'd0);

    // op_count wrap.
    for (int i = 0; i < 255; i++) begin
      issue(i[0], 2'(i), 8'(i), 0, 1'b0, 8'(i) ^ 8'h5A);
    end
    drain("wrap", 4000);
    chk("wrap_op_count_255", 32'(op_count), 32'd255);
    issue(1'b0, OP_READ, 8'hFF, 0, 1'b0, 8'h81);
    drain("wrap_last", 50);
    chk("wrap_op_count_0", 32'(op_count), 32'd0);

    chk("total_rsp", 32'(n_rsp), 32'd271);
    chk("total_start", 32'(n_start), 32'd272);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
